write_ctrl: RTL and testbench

Write-side controller for a 4-row single-bit bitcell column; it is the counterpart of the one-hot read wordline mux on the same column. It accepts one write request (2-bit row address, 1-bit data) per handshake and sequences the column's bitline drivers and one-hot write wordlines through setup, pulse and hold phases. It then signals completion with a one-cycle pulse.

---
 rtl/write_ctrl.sv | 140 ++++++++++++++
 tb/tb_write_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_ctrl.sv
// Write-side sequencer for a 4-row single-bit bitcell column: drives bitlines,
// then fires one one-hot write wordline through setup / pulse / hold phases.
module write_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [1:0] addr_i,
  input  logic       din_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       wen_o,
  output logic       wbl_o,
  output logic       wblb_o,
  output logic       wwl_0_o,
  output logic       wwl_1_o,
  output logic       wwl_2_o,
  output logic       wwl_3_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_e;

  // Timer loads are phase length minus one: the terminal-count cycle is the
  // last cycle of the phase.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  addr_q;
  logic        din_q;
  logic        ready_q;
  logic        done_q;
  logic        wen_q;
  logic        wbl_q;
  logic        wblb_q;
  logic [3:0]  wwl_q;

  function automatic logic [3:0] row_onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 2'd0;
      din_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      wbl_q   <= 1'b0;
      wblb_q  <= 1'b0;
      wwl_q   <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            state_q <= ST_SETUP;
            cnt_q   <= SETUP_LD;
            addr_q  <= addr_i;
            din_q   <= din_i;
            ready_q <= 1'b0;
            wen_q   <= 1'b1;
            wbl_q   <= din_i;
            wblb_q  <= ~din_i;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_PULSE;
            cnt_q   <= PULSE_LD;
            wwl_q   <= row_onehot(addr_q);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == 4'd0) begin
            wwl_q <= 4'd0;
            if (HOLD_CYC == 0) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              wen_q   <= 1'b0;
              wbl_q   <= 1'b0;
              wblb_q  <= 1'b0;
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LD;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            wen_q   <= 1'b0;
            wbl_q   <= 1'b0;
            wblb_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          wen_q   <= 1'b0;
          wbl_q   <= 1'b0;
          wblb_q  <= 1'b0;
          wwl_q   <= 4'd0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign wen_o   = wen_q;
  assign wbl_o   = wbl_q;
  assign wblb_o  = wblb_q;
  assign wwl_0_o = wwl_q[0];
  assign wwl_1_o = wwl_q[1];
  assign wwl_2_o = wwl_q[2];
  assign wwl_3_o = wwl_q[3];

endmodule

// File: tb/tb_write_ctrl.sv
// Bench for write_ctrl: three instances (default, shortest and longest timing)
// checked cycle by cycle against a timing-rule model of each write.
module tb_write_ctrl;

  logic clk;
  logic rst;
  logic [2:0] req;
  logic [1:0] addr [3];
  logic [2:0] din;

  wire [2:0] ready_w, done_w, wen_w, wbl_w, wblb_w;
  wire [3:0] wwl_w [3];

  int S [3] = '{1, 1, 15};
  int P [3] = '{2, 1, 15};
  int H [3] = '{1, 0, 15};

  int errors = 0;
  int checks = 0;

  write_ctrl #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_def (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]), .din_i(din[0]),
    .ready_o(ready_w[0]), .done_o(done_w[0]), .wen_o(wen_w[0]), .wbl_o(wbl_w[0]),
    .wblb_o(wblb_w[0]), .wwl_0_o(wwl_w[0][0]), .wwl_1_o(wwl_w[0][1]),
    .wwl_2_o(wwl_w[0][2]), .wwl_3_o(wwl_w[0][3]));

  write_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(0)) u_min (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]), .din_i(din[1]),
    .ready_o(ready_w[1]), .done_o(done_w[1]), .wen_o(wen_w[1]), .wbl_o(wbl_w[1]),
    .wblb_o(wblb_w[1]), .wwl_0_o(wwl_w[1][0]), .wwl_1_o(wwl_w[1][1]),
    .wwl_2_o(wwl_w[1][2]), .wwl_3_o(wwl_w[1][3]));

  write_ctrl #(.SETUP_CYC(15), .PULSE_CYC(15), .HOLD_CYC(15)) u_max (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .addr_i(addr[2]), .din_i(din[2]),
    .ready_o(ready_w[2]), .done_o(done_w[2]), .wen_o(wen_w[2]), .wbl_o(wbl_w[2]),
    .wblb_o(wblb_w[2]), .wwl_0_o(wwl_w[2][0]), .wwl_1_o(wwl_w[2][1]),
    .wwl_2_o(wwl_w[2][2]), .wwl_3_o(wwl_w[2][3]));

  always #5 clk = ~clk;

  localparam logic [8:0] IDLE_V = 9'b1_0_0_0_0_0000;

  // {ready, done, wen, wbl, wblb, wwl[3:0]}
  function automatic logic [8:0] obs(input int i);
    return {ready_w[i], done_w[i], wen_w[i], wbl_w[i], wblb_w[i], wwl_w[i]};
  endfunction

  // Expected outputs k edges after the accept edge, from the phase lengths alone.
  function automatic logic [8:0] model(input int i, input int k, input logic [1:0] a,
                                       input logic d);
    int n;
    logic busy;
    logic [3:0] wl;
    n    = S[i] + P[i] + H[i];
    busy = (k < n);
    wl   = (k >= S[i] && k < S[i] + P[i]) ? (4'b0001 << a) : 4'b0000;
    return {(k == n), (k == n), busy, busy & d, busy & ~d, wl};
  endfunction

  task automatic wait_ready(input int i);
    int t;
    t = 0;
    while (ready_w[i] !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (ready_w[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready inst%0d: ready=%b after %0d cycles, required 1", i, ready_w[i], t);
    end
  endtask

  // Caller has already driven the request; the next edge is the accept edge.
  task automatic check_txn(input int i, input logic [1:0] a, input logic d,
                           input bit keep_req, input bit scramble);
    int n;
    logic [8:0] got_v;
    logic [8:0] exp_v;
    n = S[i] + P[i] + H[i];
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      got_v = obs(i);
      exp_v = model(i, k, a, d);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL txn inst%0d a=%0d d=%0d k=%0d: got %b required %b (rdy,done,wen,wbl,wblb,wwl)",
                 i, a, d, k, got_v, exp_v);
      end
      if (scramble && k < n) begin
        req[i]  = 1'($urandom);
        addr[i] = a ^ 2'($urandom_range(1, 3));
        din[i]  = ~d;
      end else if (!keep_req) begin
        req[i] = 1'b0;
      end
    end
    if (scramble) begin
      @(posedge clk); #1;
      checks++;
      if (obs(i) !== IDLE_V) begin
        errors++;
        $display("FAIL idle_after_scramble inst%0d: got %b required %b", i, obs(i), IDLE_V);
      end
    end
  endtask

  task automatic test_reset;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== IDLE_V) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %b required %b", i, obs(i), IDLE_V);
      end
    end
    // req is high on every instance while reset is held
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== IDLE_V) begin
        errors++;
        $display("FAIL req_during_reset inst%0d: got %b required %b", i, obs(i), IDLE_V);
      end
    end
    req[1] = 1'b0;
    req[2] = 1'b0;
    #3 rst = 1'b0;
  endtask

  task automatic test_first_write;
    check_txn(0, 2'd2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [1:0] a;
    logic d;
    wait_ready(0);
    for (int r = 0; r < 4; r++) begin
      a = 2'(r);
      d = 1'(r % 2);
      req[0]  = 1'b1;
      addr[0] = a;
      din[0]  = d;
      check_txn(0, a, d, (r < 3), 1'b0);
    end
  endtask

  task automatic test_mid_change;
    wait_ready(0);
    req[0]  = 1'b1;
    addr[0] = 2'd1;
    din[0]  = 1'b0;
    check_txn(0, 2'd1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    wait_ready(0);
    req[0]  = 1'b1;
    addr[0] = 2'd0;
    din[0]  = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs(0) !== 9'b0_0_1_1_0_0001) begin
      errors++;
      $display("FAIL pre_reset_pulse: got %b required %b", obs(0), 9'b0_0_1_1_0_0001);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs(0) !== IDLE_V) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b required %b", obs(0), IDLE_V);
    end
    req[0]  = 1'b1;
    addr[0] = 2'd3;
    din[0]  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs(0) !== IDLE_V) begin
      errors++;
      $display("FAIL async_reset_held: got %b required %b", obs(0), IDLE_V);
    end
    #3 rst = 1'b0;
    check_txn(0, 2'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_corners;
    logic [1:0] a;
    logic d;
    for (int i = 1; i < 3; i++) begin
      wait_ready(i);
      a = 2'($urandom);
      d = 1'($urandom);
      req[i]  = 1'b1;
      addr[i] = a;
      din[i]  = d;
      check_txn(i, a, d, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random;
    int i;
    int gap;
    logic [1:0] a;
    logic d;
    for (int t = 0; t < 12; t++) begin
      i   = $urandom_range(0, 1);
      gap = $urandom_range(0, 2);
      a   = 2'($urandom);
      d   = 1'($urandom);
      wait_ready(i);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      req[i]  = 1'b1;
      addr[i] = a;
      din[i]  = d;
      check_txn(i, a, d, 1'b0, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    req  = 3'b111;
    addr[0] = 2'd2;
    addr[1] = 2'd0;
    addr[2] = 2'd0;
    din  = 3'b001;
    test_reset;
    test_first_write;
    test_back_to_back;
    test_mid_change;
    test_async_reset;
    test_corners;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
